ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sum8_acc.sv | 34 +++
 rtl/ram_loader.sv | 161 ++++++++++++++++
 tb/tb_ram_loader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared loader definitions: FSM state encoding and length-count helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // Counters need one extra bit so a full 256-byte load is representable.
    localparam int unsigned           CNT_W          = 9;
    localparam logic [CNT_W-1:0]      LEN_ZERO_COUNT = 9'd256;

    function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len_raw);
        return (len_raw == 8'h00) ? LEN_ZERO_COUNT : {1'b0, len_raw};
    endfunction

endpackage

// File: rtl/sum8_acc.sv
// Modulo-256 byte accumulator with synchronous clear and enable.
module sum8_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] din_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q, sum_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (en_i) begin
            sum_d = sum_q + din_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ram_loader.sv
// Streams host bytes into a RAM, optionally reads them back to compare sums,
// then releases the CPU with a one-cycle run pulse.
module ram_loader
    import cpu_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter bit         DO_VERIFY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_wren,
    output logic       mem_rden,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       cpu_run,
    output logic       done,
    output logic       error,
    output logic [7:0] checksum
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_pend_q, rd_pend_d;
    logic             success_q, success_d;
    logic             error_q, error_d;

    logic             transfer;
    logic             rd_en;
    logic             clr_sums;
    logic [7:0]       wr_sum;
    logic [7:0]       rd_sum;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_cnt_d = acc_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        error_d   = error_q;
        clr_sums  = 1'b0;

        byte_ready = (state_q == ST_WRITE) && (acc_cnt_q != len_q);
        transfer   = byte_ready && byte_valid;
        rd_en      = (state_q == ST_VERIFY) && (rd_cnt_q != len_q);

        // Each accepted byte becomes a registered write on the following cycle.
        wr_en_d   = transfer;
        wr_addr_d = transfer ? (BASE_ADDR + acc_cnt_q[7:0]) : wr_addr_q;
        wr_data_d = transfer ? byte_data : wr_data_q;
        rd_pend_d = rd_en;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    len_d     = len_to_count(len);
                    acc_cnt_d = '0;
                    rd_cnt_d  = '0;
                    error_d   = 1'b0;
                    clr_sums  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (transfer) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
                // The count reaches len in the cycle the final write is on the bus.
                if (acc_cnt_q == len_q) begin
                    state_d = DO_VERIFY ? ST_VERIFY : ST_DONE;
                end
            end
            ST_VERIFY: begin
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if ((rd_cnt_q == len_q) && rd_pend_q) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (wr_sum == rd_sum) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        success_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            acc_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
            rd_pend_q <= 1'b0;
            success_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_cnt_q <= acc_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_pend_q <= rd_pend_d;
            success_q <= success_d;
            error_q   <= error_d;
        end
    end

    sum8_acc u_wr_sum (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (clr_sums),
        .en_i  (transfer),
        .din_i (byte_data),
        .sum_o (wr_sum)
    );

    sum8_acc u_rd_sum (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (clr_sums),
        .en_i  (rd_pend_q),
        .din_i (mem_rdata),
        .sum_o (rd_sum)
    );

    // Read and write phases never overlap, so the address mux needs no priority beyond this.
    assign mem_wren  = wr_en_q;
    assign mem_rden  = rd_en;
    assign mem_addr  = rd_en ? (BASE_ADDR + rd_cnt_q[7:0]) : (wr_en_q ? wr_addr_q : 8'h00);
    assign mem_wdata = wr_en_q ? wr_data_q : 8'h00;

    assign busy     = (state_q == ST_WRITE) || (state_q == ST_VERIFY) || (state_q == ST_CHECK);
    assign done     = success_q;
    assign cpu_run  = success_q;
    assign error    = error_q;
    assign checksum = wr_sum;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: two instances (base 8'h10 and 8'hFE) share a model RAM.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'h00;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] mem_rdata = 8'h00;
    logic       sel = 1'b0;
    logic       corrupt = 1'b0;

    logic       a_ready, a_wren, a_rden, a_busy, a_run, a_done, a_error;
    logic [7:0] a_addr, a_wdata, a_sum;
    logic       b_ready, b_wren, b_rden, b_busy, b_run, b_done, b_error;
    logic [7:0] b_addr, b_wdata, b_sum;

    logic       m_ready, m_wren, m_rden, m_busy, m_run, m_done, m_error;
    logic [7:0] m_addr, m_wdata, m_sum;

    int tests = 0;
    int fails = 0;
    int wr_cnt, rd_cnt, done_cnt, run_cnt;
    logic [15:0] exp_q [$];
    logic [15:0] mon_e;
    logic [7:0]  exp_sum;
    logic [7:0]  tx [256];
    logic [7:0]  ram [256];

    always #5 clk = ~clk;

    ram_loader #(.BASE_ADDR(8'h10), .DO_VERIFY(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_ready),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wren(a_wren), .mem_rden(a_rden),
        .mem_rdata(mem_rdata), .busy(a_busy), .cpu_run(a_run), .done(a_done),
        .error(a_error), .checksum(a_sum)
    );

    ram_loader #(.BASE_ADDR(8'hFE), .DO_VERIFY(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_ready),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wren(b_wren), .mem_rden(b_rden),
        .mem_rdata(mem_rdata), .busy(b_busy), .cpu_run(b_run), .done(b_done),
        .error(b_error), .checksum(b_sum)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_wren  = sel ? b_wren  : a_wren;
    assign m_rden  = sel ? b_rden  : a_rden;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_run   = sel ? b_run   : a_run;
    assign m_done  = sel ? b_done  : a_done;
    assign m_error = sel ? b_error : a_error;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_sum   = sel ? b_sum   : a_sum;

    // Synchronous-read model RAM; optionally flips a bit when address 8'h11 is read.
    always @(posedge clk) begin
        if (m_wren) ram[m_addr] <= m_wdata;
        if (m_rden) mem_rdata <= ram[m_addr] ^ ((corrupt && m_addr == 8'h11) ? 8'h01 : 8'h00);
    end

    always @(negedge clk) begin
        if (rst) begin
            if (m_wren) begin
                wr_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write got addr=%h data=%h, required no write", m_addr, m_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_addr, m_wdata} !== mon_e) begin
                        fails++;
                        $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                                 m_addr, m_wdata, mon_e[15:8], mon_e[7:0]);
                    end
                end
            end
            if (m_rden) rd_cnt++;
            if (m_wren && m_rden) begin
                tests++;
                fails++;
                $display("FAIL wren_rden_overlap got both=1, required exclusive");
            end
            if (m_done) done_cnt++;
            if (m_run)  run_cnt++;
        end
    end

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; run_cnt = 0;
        exp_q.delete();
    endtask

    task automatic start_load(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0; len = 8'h00;
        exp_sum = 8'h00;
    endtask

    // Offers tx[idx]; on handshake queues the expected write and returns #1 after the accept edge.
    task automatic send_one(input logic [7:0] base, input int idx);
        int t;
        byte_valid = 1'b1;
        byte_data  = tx[idx];
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_ready && t < 20);
        if (!m_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout got ready=0, required accept of byte %0d", idx);
        end else begin
            exp_q.push_back({base + 8'(idx), tx[idx]});
            exp_sum = exp_sum + tx[idx];
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (m_busy && t < 2000);
        if (m_busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout got busy=1, required completion", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_done(input string name, input int n, input logic [7:0] sum_req);
        tests++;
        if (wr_cnt !== n || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL %s_writes got %0d (pending %0d), required %0d", name, wr_cnt, exp_q.size(), n);
        end
        tests++;
        if (rd_cnt !== n) begin
            fails++;
            $display("FAIL %s_reads got %0d, required %0d", name, rd_cnt, n);
        end
        tests++;
        if (m_sum !== sum_req) begin
            fails++;
            $display("FAIL %s_checksum got %h, required %h", name, m_sum, sum_req);
        end
        tests++;
        if (done_cnt !== 1 || run_cnt !== 1 || m_error !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulses got done=%0d run=%0d err=%b, required 1 1 0", name, done_cnt, run_cnt, m_error);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        start = 1'b1; len = 8'h03; byte_valid = 1'b1; byte_data = 8'h55;
        repeat (2) @(posedge clk); #1;
        tests++;
        if ({m_ready, m_wren, m_rden, m_busy, m_done, m_run, m_error} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags got %b, required 0000000",
                     {m_ready, m_wren, m_rden, m_busy, m_done, m_run, m_error});
        end
        tests++;
        if ({m_addr, m_wdata, m_sum} !== 24'h0) begin
            fails++;
            $display("FAIL reset_buses got %h, required 000000", {m_addr, m_wdata, m_sum});
        end
        start = 1'b0; byte_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (m_busy !== 1'b0 || m_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_release got busy=%b ready=%b, required 0 0", m_busy, m_ready);
        end
    endtask

    // Three bytes at base 8'h10; a start pulse mid-load must be ignored.
    task automatic test_basic();
        sel = 1'b0; clear_counts();
        tx[0] = 8'h0A; tx[1] = 8'h05; tx[2] = 8'h01;
        start_load(8'h03);
        tests++;
        if (m_busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy got %b, required 1", m_busy);
        end
        send_one(8'h10, 0);
        start = 1'b1; len = 8'h01;
        send_one(8'h10, 1);
        start = 1'b0; len = 8'h00;
        send_one(8'h10, 2);
        byte_valid = 1'b0;
        wait_idle("basic");
        check_done("basic", 3, 8'h10);
    endtask

    task automatic test_gaps();
        sel = 1'b0; clear_counts();
        tx[0] = 8'h33; tx[1] = 8'h44; tx[2] = 8'h55;
        start_load(8'h03);
        send_one(8'h10, 0);
        byte_valid = 1'b0;
        @(posedge clk); #1;
        send_one(8'h10, 1);
        send_one(8'h10, 2);
        byte_data = 8'hEE;
        @(negedge clk);
        tests++;
        if (m_ready !== 1'b0) begin
            fails++;
            $display("FAIL gaps_ready_drop got %b, required 0", m_ready);
        end
        wait_idle("gaps");
        byte_valid = 1'b0;
        check_done("gaps", 3, exp_sum);
    endtask

    task automatic test_wrap();
        sel = 1'b1; clear_counts();
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        start_load(8'h04);
        for (int i = 0; i < 4; i++) send_one(8'hFE, i);
        byte_valid = 1'b0;
        wait_idle("wrap");
        check_done("wrap", 4, 8'hAA);
        sel = 1'b0;
    endtask

    task automatic test_corrupt();
        sel = 1'b0; clear_counts(); corrupt = 1'b1;
        tx[0] = 8'h0A; tx[1] = 8'h05; tx[2] = 8'h01;
        start_load(8'h03);
        for (int i = 0; i < 3; i++) send_one(8'h10, i);
        byte_valid = 1'b0;
        wait_idle("corrupt");
        repeat (5) @(negedge clk);
        tests++;
        if (m_error !== 1'b1 || done_cnt !== 0 || run_cnt !== 0) begin
            fails++;
            $display("FAIL corrupt_error got err=%b done=%0d run=%0d, required 1 0 0", m_error, done_cnt, run_cnt);
        end
        corrupt = 1'b0; clear_counts();
        start_load(8'h03);
        tests++;
        if (m_error !== 1'b0) begin
            fails++;
            $display("FAIL error_cleared got %b, required 0", m_error);
        end
        for (int i = 0; i < 3; i++) send_one(8'h10, i);
        byte_valid = 1'b0;
        wait_idle("recover");
        check_done("recover", 3, 8'h10);
    endtask

    task automatic test_abort();
        sel = 1'b0; clear_counts();
        for (int i = 0; i < 5; i++) tx[i] = 8'(i + 1);
        start_load(8'h05);
        send_one(8'h10, 0);
        send_one(8'h10, 1);
        rst = 1'b0;
        #1;
        tests++;
        if ({m_wren, m_busy, m_ready, m_sum} !== 11'h0) begin
            fails++;
            $display("FAIL abort_outputs got wren=%b busy=%b ready=%b sum=%h, required 0 0 0 00",
                     m_wren, m_busy, m_ready, m_sum);
        end
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (wr_cnt !== 1 || m_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet got writes=%0d busy=%b, required 1 0", wr_cnt, m_busy);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_len0();
        sel = 1'b0; clear_counts();
        for (int i = 0; i < 256; i++) tx[i] = 8'(i);
        start_load(8'h00);
        for (int i = 0; i < 256; i++) send_one(8'h10, i);
        byte_valid = 1'b0;
        wait_idle("len0");
        check_done("len0", 256, 8'h80);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish, required finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_corrupt();
        test_abort();
        test_len0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
